// File: rtl/cr_kme_kop_kdf_keypacker_if.sv
// Handshake bundle for the KDF key packer: key command, KDF beat stream and
// packed-word output. Optional out_parity is present with KME_KEYPACKER_PARITY_EN.
interface cr_kme_kop_kdf_keypacker_if;
    logic         cmd_valid;
    logic [3:0]   cmd_num_beats;
    logic         cmd_ack;
    logic [63:0]  kdf_keybuilder_data;
    logic         kdf_keybuilder_valid;
    logic         keybuilder_kdf_stall;
    logic         out_valid;
    logic [255:0] out_data;
    logic         out_last;
    logic         out_ack;
    logic         err_illegal_len;
`ifdef KME_KEYPACKER_PARITY_EN
    logic [3:0]   out_parity;
`endif

    // Packer side.
    modport slave (
        input  cmd_valid, cmd_num_beats, kdf_keybuilder_data, kdf_keybuilder_valid, out_ack,
        output cmd_ack, keybuilder_kdf_stall, out_valid, out_data, out_last, err_illegal_len
`ifdef KME_KEYPACKER_PARITY_EN
        , output out_parity
`endif
    );

    // Command source / KDF / word consumer side.
    modport master (
        output cmd_valid, cmd_num_beats, kdf_keybuilder_data, kdf_keybuilder_valid, out_ack,
        input  cmd_ack, keybuilder_kdf_stall, out_valid, out_data, out_last, err_illegal_len
`ifdef KME_KEYPACKER_PARITY_EN
        , input out_parity
`endif
    );
endinterface

// File: rtl/cr_kme_kop_kdf_keypacker.sv
// KDF key packer: gathers 64-bit derived-key beats into 256-bit big-endian
// lane words (first beat in [255:192]), zero-pads a short final word and flags
// it last. Keys longer than 8 beats are clamped to 8 with an error pulse.
// Optional per-lane parity output: define KME_KEYPACKER_PARITY_EN.
module cr_kme_kop_kdf_keypacker #(
    parameter int MAX_BEATS = 8,
    parameter int LANES     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    cr_kme_kop_kdf_keypacker_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUT    = 2'd2,
        RETIRE = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [3:0]     rem_r;
    logic [1:0]     lane_r;
    logic [255:0]   word_r;
    logic           last_r;
    logic           load_s;
    logic           take_s;
    logic           drain_s;
    logic [3:0]     beats_s;
`ifdef KME_KEYPACKER_PARITY_EN
    logic [3:0]     parity_r;
`endif

    // Lengths above the beat-counter ceiling are clamped so the counter cannot wrap.
    assign beats_s = (bus.cmd_num_beats > 4'(MAX_BEATS)) ? 4'(MAX_BEATS) : bus.cmd_num_beats;

    // Outputs decoded straight from registered state and the word register.
    assign bus.keybuilder_kdf_stall = (state_r != ACCUM);
    assign bus.out_valid            = (state_r == OUT);
    assign bus.cmd_ack              = (state_r == RETIRE);
    assign bus.out_data             = word_r;
    assign bus.out_last             = last_r;
    assign bus.err_illegal_len      = (state_r == IDLE) && bus.cmd_valid
                                      && (bus.cmd_num_beats > 4'(MAX_BEATS));
`ifdef KME_KEYPACKER_PARITY_EN
    assign bus.out_parity           = parity_r;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        take_s  = 1'b0;
        drain_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.cmd_valid) begin
                    load_s  = 1'b1;
                    state_s = (bus.cmd_num_beats == 4'd0) ? RETIRE : ACCUM;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                if (bus.kdf_keybuilder_valid) begin
                    take_s = 1'b1;
                    if ((lane_r == 2'(LANES - 1)) || (rem_r == 4'd1)) begin
                        state_s = OUT;
                    end else begin
                        state_s = ACCUM;
                    end
                end else begin
                    state_s = ACCUM;
                end
            end
            OUT: begin
                if (bus.out_ack) begin
                    drain_s = 1'b1;
                    state_s = last_r ? RETIRE : ACCUM;
                end else begin
                    state_s = OUT;
                end
            end
            RETIRE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Beat counter, lane pointer and word assembly; word clears once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r    <= 4'd0;
            lane_r   <= 2'd0;
            word_r   <= 256'd0;
            last_r   <= 1'b0;
`ifdef KME_KEYPACKER_PARITY_EN
            parity_r <= 4'd0;
`endif
        end else if (load_s) begin
            rem_r    <= beats_s;
            lane_r   <= 2'd0;
            word_r   <= 256'd0;
            last_r   <= 1'b0;
`ifdef KME_KEYPACKER_PARITY_EN
            parity_r <= 4'd0;
`endif
        end else if (take_s) begin
            for (int k = 0; k < LANES; k++) begin
                if (lane_r == k[1:0]) begin
                    word_r[255 - 64*k -: 64] <= bus.kdf_keybuilder_data;
`ifdef KME_KEYPACKER_PARITY_EN
                    parity_r[k] <= ^bus.kdf_keybuilder_data;
`endif
                end
            end
            rem_r  <= rem_r - 4'd1;
            lane_r <= lane_r + 2'd1;
            last_r <= (rem_r == 4'd1);
        end else if (drain_s) begin
            lane_r   <= 2'd0;
            word_r   <= 256'd0;
            last_r   <= 1'b0;
`ifdef KME_KEYPACKER_PARITY_EN
            parity_r <= 4'd0;
`endif
        end else begin
            rem_r <= rem_r;
        end
    end
endmodule

// File: tb/tb_cr_kme_kop_kdf_keypacker.sv
// Directed bench for the KDF key packer: full key, backpressured two-word key,
// empty key, over-length key, mid-key reset and (optionally) lane parity.
module tb_cr_kme_kop_kdf_keypacker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    cr_kme_kop_kdf_keypacker_if bus ();

    cr_kme_kop_kdf_keypacker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [63:0] A0 = 64'h1111111111111111, A1 = 64'h2222222222222222,
                            A2 = 64'h3333333333333333, A3 = 64'h4444444444444444;
    localparam logic [63:0] B0 = 64'hB0B0B0B0B0B0B0B0, B1 = 64'hB1B1B1B1B1B1B1B1,
                            B2 = 64'hB2B2B2B2B2B2B2B2, B3 = 64'hB3B3B3B3B3B3B3B3,
                            B4 = 64'hB4B4B4B4B4B4B4B4, B5 = 64'hB5B5B5B5B5B5B5B5;
    localparam logic [63:0] C0 = 64'hC0C0C0C0C0C0C0C0;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_num_beats = 4'd0;
        bus.kdf_keybuilder_data = 64'd0;
        bus.kdf_keybuilder_valid = 1'b0;
        bus.out_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_stall", {255'd0, bus.keybuilder_kdf_stall}, 256'd1);
        chk("rst_valid", {255'd0, bus.out_valid}, 256'd0);
        chk("rst_data",  bus.out_data, 256'd0);
        chk("rst_ack",   {255'd0, bus.cmd_ack}, 256'd0);
        rst_n = 1'b1;
        step();

        // Valid in IDLE is ignored.
        bus.kdf_keybuilder_valid = 1'b1;
        bus.kdf_keybuilder_data = 64'hDEAD;
        step();
        step();
        chk("idle_stall", {255'd0, bus.keybuilder_kdf_stall}, 256'd1);
        chk("idle_valid", {255'd0, bus.out_valid}, 256'd0);
        bus.kdf_keybuilder_valid = 1'b0;

        // Key 1: four beats, out_ack tied high.
        bus.out_ack = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_num_beats = 4'd4;
        step();
        bus.cmd_valid = 1'b0;
        chk("k1_stall_low", {255'd0, bus.keybuilder_kdf_stall}, 256'd0);
        bus.kdf_keybuilder_valid = 1'b1;
        bus.kdf_keybuilder_data = A0; step();
        bus.kdf_keybuilder_data = A1; step();
        bus.kdf_keybuilder_data = A2; step();
        chk("k1_no_early_valid", {255'd0, bus.out_valid}, 256'd0);
        bus.kdf_keybuilder_data = A3; step();
        bus.kdf_keybuilder_valid = 1'b0;
        chk("k1_valid", {255'd0, bus.out_valid}, 256'd1);
        chk("k1_data",  bus.out_data, {A0, A1, A2, A3});
        chk("k1_last",  {255'd0, bus.out_last}, 256'd1);
        chk("k1_stall", {255'd0, bus.keybuilder_kdf_stall}, 256'd1);
        step();
        chk("k1_cmd_ack", {255'd0, bus.cmd_ack}, 256'd1);
        chk("k1_valid_drop", {255'd0, bus.out_valid}, 256'd0);
        step();
        chk("k1_cmd_ack_end", {255'd0, bus.cmd_ack}, 256'd0);

        // Key 2: six beats, first word held off for three cycles.
        bus.out_ack = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_num_beats = 4'd6;
        step();
        bus.cmd_valid = 1'b0;
        bus.kdf_keybuilder_valid = 1'b1;
        bus.kdf_keybuilder_data = B0; step();
        bus.kdf_keybuilder_data = B1; step();
        bus.kdf_keybuilder_data = B2; step();
        bus.kdf_keybuilder_data = B3; step();
        bus.kdf_keybuilder_data = B4;
        for (int i = 0; i < 3; i++) begin
            chk("k2_w1_valid", {255'd0, bus.out_valid}, 256'd1);
            chk("k2_w1_data",  bus.out_data, {B0, B1, B2, B3});
            chk("k2_w1_last",  {255'd0, bus.out_last}, 256'd0);
            chk("k2_hold_stall", {255'd0, bus.keybuilder_kdf_stall}, 256'd1);
            step();
        end
        bus.out_ack = 1'b1;
        step();
        chk("k2_resume_stall", {255'd0, bus.keybuilder_kdf_stall}, 256'd0);
        chk("k2_resume_valid", {255'd0, bus.out_valid}, 256'd0);
        step();
        bus.kdf_keybuilder_data = B5; step();
        bus.kdf_keybuilder_valid = 1'b0;
        chk("k2_w2_valid", {255'd0, bus.out_valid}, 256'd1);
        chk("k2_w2_data",  bus.out_data, {B4, B5, 64'd0, 64'd0});
        chk("k2_w2_last",  {255'd0, bus.out_last}, 256'd1);
        step();
        chk("k2_cmd_ack", {255'd0, bus.cmd_ack}, 256'd1);
        step();

        // Key 3: zero beats, straight to retire.
        bus.cmd_valid = 1'b1;
        bus.cmd_num_beats = 4'd0;
        #1;
        chk("k3_no_err", {255'd0, bus.err_illegal_len}, 256'd0);
        step();
        bus.cmd_valid = 1'b0;
        chk("k3_cmd_ack", {255'd0, bus.cmd_ack}, 256'd1);
        chk("k3_valid",   {255'd0, bus.out_valid}, 256'd0);
        chk("k3_stall",   {255'd0, bus.keybuilder_kdf_stall}, 256'd1);
        step();
        chk("k3_cmd_ack_end", {255'd0, bus.cmd_ack}, 256'd0);

        // Key 4: twelve requested, clamped to eight.
        bus.cmd_valid = 1'b1;
        bus.cmd_num_beats = 4'd12;
        #1;
        chk("k4_err", {255'd0, bus.err_illegal_len}, 256'd1);
        step();
        bus.cmd_valid = 1'b0;
        chk("k4_err_end", {255'd0, bus.err_illegal_len}, 256'd0);
        bus.kdf_keybuilder_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.kdf_keybuilder_data = 64'hD0 + 64'(i);
            step();
        end
        chk("k4_w1_valid", {255'd0, bus.out_valid}, 256'd1);
        chk("k4_w1_data",  bus.out_data, {64'hD0, 64'hD1, 64'hD2, 64'hD3});
        chk("k4_w1_last",  {255'd0, bus.out_last}, 256'd0);
        bus.kdf_keybuilder_data = 64'hD4;
        step();
        for (int i = 4; i < 8; i++) begin
            bus.kdf_keybuilder_data = 64'hD0 + 64'(i);
            step();
        end
        bus.kdf_keybuilder_valid = 1'b0;
        chk("k4_w2_valid", {255'd0, bus.out_valid}, 256'd1);
        chk("k4_w2_data",  bus.out_data, {64'hD4, 64'hD5, 64'hD6, 64'hD7});
        chk("k4_w2_last",  {255'd0, bus.out_last}, 256'd1);
        step();
        chk("k4_cmd_ack", {255'd0, bus.cmd_ack}, 256'd1);
        step();
        chk("k4_idle_stall", {255'd0, bus.keybuilder_kdf_stall}, 256'd1);

        // Key 5: reset after two beats, then a one-beat key.
        bus.cmd_valid = 1'b1;
        bus.cmd_num_beats = 4'd4;
        step();
        bus.cmd_valid = 1'b0;
        bus.kdf_keybuilder_valid = 1'b1;
        bus.kdf_keybuilder_data = A0; step();
        bus.kdf_keybuilder_data = A1; step();
        bus.kdf_keybuilder_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("k5_rst_stall", {255'd0, bus.keybuilder_kdf_stall}, 256'd1);
        chk("k5_rst_data",  bus.out_data, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        bus.cmd_valid = 1'b1;
        bus.cmd_num_beats = 4'd1;
        step();
        bus.cmd_valid = 1'b0;
        bus.kdf_keybuilder_valid = 1'b1;
        bus.kdf_keybuilder_data = C0; step();
        bus.kdf_keybuilder_valid = 1'b0;
        chk("k5_valid", {255'd0, bus.out_valid}, 256'd1);
        chk("k5_data",  bus.out_data, {C0, 64'd0, 64'd0, 64'd0});
        chk("k5_last",  {255'd0, bus.out_last}, 256'd1);
        step();
        chk("k5_cmd_ack", {255'd0, bus.cmd_ack}, 256'd1);
        step();

`ifdef KME_KEYPACKER_PARITY_EN
        // Parity: lane k in bit k; lanes 1,3,7,0 -> bits 0 and 2 set.
        bus.cmd_valid = 1'b1;
        bus.cmd_num_beats = 4'd4;
        step();
        bus.cmd_valid = 1'b0;
        bus.kdf_keybuilder_valid = 1'b1;
        bus.kdf_keybuilder_data = 64'h1; step();
        bus.kdf_keybuilder_data = 64'h3; step();
        bus.kdf_keybuilder_data = 64'h7; step();
        bus.kdf_keybuilder_data = 64'h0; step();
        bus.kdf_keybuilder_valid = 1'b0;
        chk("par_valid", {255'd0, bus.out_valid}, 256'd1);
        chk("par_bits", {252'd0, bus.out_parity}, {252'd0, 4'b0101});
        step();
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
